// File: rtl/prbs17_checker.sv
// Self-synchronizing PRBS17 (x^17 + x^14 + 1) word checker, 16 bits per clock.
// Locks on a clean received stream, then checks against a local LFSR and counts bit errors.
module prbs17_checker #(
    parameter int LOCK_THRESHOLD   = 4,
    parameter int UNLOCK_THRESHOLD = 4,
    parameter int ERRCNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             din,
    input  logic                    din_valid,
    input  logic                    clr,
    output logic                    locked,
    output logic                    err_flag,
    output logic [4:0]              err_bits,
    output logic [ERRCNT_WIDTH-1:0] err_count
);

    // state  | meaning
    // FILL   | loading the 17-bit history from the first two valid words
    // SEARCH | self-synchronizing on received bits, counting good words
    // LOCKED | local LFSR generation, errors flagged and counted
    typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

    localparam int SW = ERRCNT_WIDTH + 5;
    localparam logic [3:0] LOCK_T   = 4'(LOCK_THRESHOLD);
    localparam logic [3:0] UNLOCK_T = 4'(UNLOCK_THRESHOLD);

    state_t                  state;
    logic [16:0]             hist;
    logic                    fill_cnt;
    logic [3:0]              good_cnt;
    logic [3:0]              bad_cnt;

    logic [15:0]             pred;
    logic [15:0]             err_vec;
    logic [16:0]             gen_hist;
    logic [4:0]              err_pop;
    logic [SW-1:0]           sum;
    logic [ERRCNT_WIDTH-1:0] cnt_next;
    logic                    word_err;
    logic                    word_good;

    // Bits 14/15 depend on bits 0/1 of this same word, so the extension is built serially.
    always_comb begin
        logic [32:0] x;
        x    = {16'h0000, hist};
        pred = '0;
        for (int k = 0; k < 16; k++) begin
            pred[k]  = x[k] ^ x[k+3];
            x[17+k]  = (state == LOCKED) ? pred[k] : din[k];
        end
        gen_hist = x[32:16];
    end

    always_comb begin
        err_vec = din ^ pred;
        err_pop = '0;
        for (int k = 0; k < 16; k++) begin
            err_pop = err_pop + 5'(err_vec[k]);
        end
        word_err  = |err_vec;
        word_good = !word_err && (din != 16'h0000);
        sum       = SW'(err_count) + SW'(err_pop);
        cnt_next  = (sum > SW'({ERRCNT_WIDTH{1'b1}})) ? '1 : sum[ERRCNT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            hist      <= '0;
            fill_cnt  <= 1'b0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_flag  <= 1'b0;
            err_bits  <= '0;
            err_count <= '0;
        end else begin
            err_flag <= 1'b0;
            if (clr) begin
                err_count <= '0;
            end else if (din_valid && state == LOCKED && word_err) begin
                err_count <= cnt_next;
            end

            if (din_valid) begin
                case (state)
                    FILL: begin
                        hist     <= gen_hist;
                        fill_cnt <= 1'b1;
                        if (fill_cnt) begin
                            state <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        hist <= gen_hist;
                        if (word_good) begin
                            good_cnt <= good_cnt + 4'd1;
                            if (good_cnt == LOCK_T - 4'd1) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                bad_cnt <= '0;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (word_err) begin
                            err_flag <= 1'b1;
                            err_bits <= err_pop;
                            bad_cnt  <= bad_cnt + 4'd1;
                            if (bad_cnt == UNLOCK_T - 4'd1) begin
                                // Drop back to self-sync: resume from the received bits.
                                state    <= SEARCH;
                                locked   <= 1'b0;
                                good_cnt <= '0;
                                hist     <= {din, hist[16]};
                            end else begin
                                hist <= gen_hist;
                            end
                        end else begin
                            bad_cnt  <= '0;
                            err_bits <= '0;
                            hist     <= gen_hist;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs17_checker.sv
// Bench for prbs17_checker: bit-serial PRBS17 generator and bit-stream reference model,
// two DUTs (16-bit and 4-bit error counters) driven by the same stimulus.
module tb_prbs17_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din;
    logic        din_valid;
    logic        clr;

    logic        locked_a, err_flag_a, locked_b, err_flag_b;
    logic [4:0]  err_bits_a, err_bits_b;
    logic [15:0] err_count_a;
    logic [3:0]  err_count_b;

    prbs17_checker dut_a (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr(clr),
        .locked(locked_a), .err_flag(err_flag_a), .err_bits(err_bits_a), .err_count(err_count_a)
    );

    prbs17_checker #(.ERRCNT_WIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clr(clr),
        .locked(locked_b), .err_flag(err_flag_b), .err_bits(err_bits_b), .err_count(err_count_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef enum {M_FILL, M_SEARCH, M_LOCKED} mmode_t;
    mmode_t m_mode;
    int     m_fill, m_good, m_bad, m_bits, m_cnt16, m_cnt4;
    bit     m_flag;
    bit     m_q[$];
    bit     g_q[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_FILL;
        m_fill = 0; m_good = 0; m_bad = 0; m_bits = 0;
        m_cnt16 = 0; m_cnt4 = 0; m_flag = 0;
        m_q.delete();
        repeat (17) m_q.push_back(1'b0);
    endfunction

    // Stream-level model: each bit predicted from the bits 17 and 14 places earlier.
    function automatic void model_step(logic [15:0] d, bit v, bit c);
        int nerr;
        m_flag = 0;
        if (v) begin
            nerr = 0;
            for (int k = 0; k < 16; k++) begin
                bit p;
                p = m_q[m_q.size()-17] ^ m_q[m_q.size()-14];
                if (p != d[k]) nerr++;
                m_q.push_back((m_mode == M_LOCKED) ? p : d[k]);
            end
            while (m_q.size() > 17) void'(m_q.pop_front());
            case (m_mode)
                M_FILL: begin
                    m_fill++;
                    if (m_fill == 2) m_mode = M_SEARCH;
                end
                M_SEARCH: begin
                    if (nerr == 0 && d != 0) m_good++; else m_good = 0;
                    if (m_good == 4) begin m_mode = M_LOCKED; m_bad = 0; end
                end
                default: begin
                    if (nerr != 0) begin
                        m_bad++;
                        m_flag = 1;
                        m_bits = nerr;
                        m_cnt16 = (m_cnt16 + nerr > 65535) ? 65535 : m_cnt16 + nerr;
                        m_cnt4  = (m_cnt4 + nerr > 15) ? 15 : m_cnt4 + nerr;
                    end else begin
                        m_bad = 0;
                        m_bits = 0;
                    end
                    if (m_bad == 4) begin
                        m_mode = M_SEARCH;
                        m_good = 0;
                        for (int k = 0; k < 16; k++) m_q[m_q.size()-16+k] = d[k];
                    end
                end
            endcase
        end
        if (c) begin m_cnt16 = 0; m_cnt4 = 0; end
    endfunction

    function automatic logic [15:0] gen_word();
        logic [15:0] w;
        for (int k = 0; k < 16; k++) begin
            bit b;
            b = g_q[g_q.size()-17] ^ g_q[g_q.size()-14];
            g_q.push_back(b);
            w[k] = b;
        end
        while (g_q.size() > 17) void'(g_q.pop_front());
        return w;
    endfunction

    task automatic compare_all();
        check("locked",      32'(locked_a),    32'(m_mode == M_LOCKED));
        check("err_flag",    32'(err_flag_a),  32'(m_flag));
        check("err_bits",    32'(err_bits_a),  32'(m_bits));
        check("err_count",   32'(err_count_a), 32'(m_cnt16));
        check("locked_w4",   32'(locked_b),    32'(m_mode == M_LOCKED));
        check("err_flag_w4", 32'(err_flag_b),  32'(m_flag));
        check("err_bits_w4", 32'(err_bits_b),  32'(m_bits));
        check("err_count_w4",32'(err_count_b), 32'(m_cnt4));
    endtask

    task automatic cycle(logic [15:0] d, bit v, bit c);
        din = d; din_valid = v; clr = c;
        @(posedge clk);
        model_step(d, v, c);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check("rst_locked",    32'(locked_a),    32'd0);
        check("rst_err_flag",  32'(err_flag_a),  32'd0);
        check("rst_err_bits",  32'(err_bits_a),  32'd0);
        check("rst_err_count", 32'(err_count_a), 32'd0);
        compare_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] w;
        bit flag_seen;
        int nv;
        int pos;

        din = '0; din_valid = 1'b0; clr = 1'b0; reset = 1'b0;
        for (int i = 0; i < 17; i++) g_q.push_back(bit'($urandom_range(0, 1)));
        g_q[0] = 1'b1;

        // Clean stream from reset: lock exactly at valid word 6, no errors.
        do_reset();
        flag_seen = 0;
        for (int i = 1; i <= 10000; i++) begin
            cycle(gen_word(), 1, 0);
            if (i == 5) check("lock_before_6", 32'(locked_a), 32'd0);
            if (i == 6) check("lock_at_6", 32'(locked_a), 32'd1);
            if (err_flag_a) flag_seen = 1;
        end
        check("clean_err_count", 32'(err_count_a), 32'd0);
        check("clean_no_flag", 32'(flag_seen), 32'd0);

        // Single-bit error: one pulse, one counted bit, no multiplication.
        w = gen_word();
        w[5] = ~w[5];
        cycle(w, 1, 0);
        check("flip_flag", 32'(err_flag_a), 32'd1);
        check("flip_bits", 32'(err_bits_a), 32'd1);
        check("flip_count", 32'(err_count_a), 32'd1);
        check("flip_locked", 32'(locked_a), 32'd1);
        cycle(gen_word(), 1, 0);
        check("flip_next_bits", 32'(err_bits_a), 32'd0);
        check("flip_next_flag", 32'(err_flag_a), 32'd0);

        // Four random words drop lock; clean stream relocks.
        for (int i = 1; i <= 4; i++) begin
            void'(gen_word());
            cycle(16'($urandom), 1, 0);
            check("unlock_seq", 32'(locked_a), 32'(i < 4));
        end
        repeat (8) cycle(gen_word(), 1, 0);
        check("relock", 32'(locked_a), 32'd1);

        // Saturation of the 4-bit counter and clear priority.
        cycle(gen_word(), 1, 1);
        check("clr_a", 32'(err_count_a), 32'd0);
        for (int i = 0; i < 20; i++) begin
            w = gen_word();
            pos = $urandom_range(0, 15);
            w[pos] = ~w[pos];
            cycle(w, 1, 0);
            cycle(gen_word(), 1, 0);
        end
        check("sat_w4", 32'(err_count_b), 32'd15);
        check("count_20", 32'(err_count_a), 32'd20);
        check("sat_locked", 32'(locked_b), 32'd1);
        cycle(gen_word(), 1, 1);
        check("clr_w4", 32'(err_count_b), 32'd0);
        w = gen_word();
        w[0] = ~w[0];
        cycle(w, 1, 1);
        check("clr_vs_err_w4", 32'(err_count_b), 32'd0);
        check("clr_vs_err_a", 32'(err_count_a), 32'd0);
        check("clr_vs_err_flag", 32'(err_flag_a), 32'd1);

        // din_valid toggling: lock after 6 valid words, then reset while locked.
        do_reset();
        nv = 0;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) begin
                cycle(gen_word(), 1, 0);
                nv++;
                check("toggle_lock", 32'(locked_a), 32'(nv >= 6));
            end else begin
                cycle(16'($urandom), 0, 0);
                check("toggle_idle_flag", 32'(err_flag_a), 32'd0);
            end
        end
        do_reset();
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                cycle(gen_word(), 1, 0);
                nv++;
                check("relock_after_rst", 32'(locked_a), 32'(nv >= 6));
            end else begin
                cycle(16'($urandom), 0, 0);
            end
        end

        // All-zero input never locks.
        do_reset();
        repeat (300) cycle(16'h0000, 1, 0);
        check("zero_no_lock", 32'(locked_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prbs17_checker.md
# prbs17_checker

Receive-side PRBS17 checker for the ETROC2 readout test path. Accepts the 16-bit-per-clock PRBS17 word stream produced by the readout PRBS generator (recurrence s[n+17] = s[n] ^ s[n+3]), self-synchronizes to it and declares lock. Once locked, it runs a local free-running LFSR, flags word errors, and accumulates a saturating bit-error count for slow-control readback.

## Interface
- LOCK_THRESHOLD, 4: consecutive error-free nonzero words in SEARCH needed to lock (1..15)
- UNLOCK_THRESHOLD, 4: consecutive errored words in LOCKED needed to drop lock (1..15)
- ERRCNT_WIDTH, 16: width of bit-error counter
- clk  input  1  clock, 40 MHz word clock
- reset  input  1  asynchronous, active-high; clears all state
- din  input  16  received word; din[0] is the earliest bit in stream order
- din_valid  input  1  din qualifier; state advances only when high
- clr  input  1  synchronous clear of err_count (priority over increment)
- locked  output  1  high while FSM is in LOCKED
- err_flag  output  1  one-cycle pulse: last valid word in LOCKED had ≥1 bit error
- err_bits  output  5  popcount of error bits of the last valid LOCKED word (0..16)
- err_count  output  ERRCNT_WIDTH  saturating total of bit errors seen in LOCKED

## Operation
- History H[16:0] holds the last 17 stream bits, H[0] oldest. Extended vector x[32:0] = {din, H} (x[17+k] = din[k]).
- Predicted bit pred[k] = x[k] ^ x[k+3], k = 0..15. In LOCKED, x[17+k] uses pred[k] instead of din[k] (local generation); in SEARCH, received bits are used (self-sync).
- Error vector e = din ^ pred; word is errored when e != 0.
- FSM (advances only on din_valid):
  - FILL: H <= x[32:16] from din; fill counter counts 2 valid words, then -> SEARCH. No error checking.
  - SEARCH: H loaded from received bits. Good word = (e == 0) and (din != 0); good_cnt++ on good word, else good_cnt <= 0. good_cnt reaching LOCK_THRESHOLD -> LOCKED, bad_cnt <= 0.
  - LOCKED: H <= locally generated bits. e != 0: bad_cnt++, err_flag <= 1, err_bits <= popcount(e), err_count += popcount(e); e == 0: bad_cnt <= 0, err_bits <= 0. bad_cnt reaching UNLOCK_THRESHOLD -> SEARCH, good_cnt <= 0, H reloaded from received din on that same edge.
- All-zero input never counts as good, so the LFSR lock-up state cannot produce lock.
- err_count saturates at 2^ERRCNT_WIDTH−1; clr on the same edge as an increment yields 0.
- err_count and err_bits unaffected by SEARCH/FILL words; err_flag 0 outside LOCKED.

## Timing
- Reset values: state FILL, H = 0, counters 0, locked = 0, err_flag = 0, err_bits = 0, err_count = 0.
- Reset asserted mid-operation clears everything asynchronously; first valid word after release is FILL word 1.
- Latency: outputs registered; response to word accepted at edge N is visible after edge N.
- Lock from reset with clean stream: edge of valid word 2 + LOCK_THRESHOLD (word 6 with defaults) sets locked.
- Unlock: locked falls after the edge of the UNLOCK_THRESHOLDth consecutive errored word.
- din_valid low: no state, H or counter change; err_flag is 0 that cycle; err_bits holds.
- err_flag is a single-cycle pulse per errored valid word; back-to-back errored words give consecutive high cycles.

## Test plan
- Reset, then clean PRBS17 from generator, din_valid = 1 always -> locked rises after valid word 6; err_count = 0 after 10000 words; err_flag never high.
- Locked, flip din[5] in one word -> err_flag one cycle, err_bits = 1, err_count = 1, locked stays 1, next word err_bits = 0 (no error multiplication).
- Locked, 4 consecutive random words -> locked falls after 4th; clean stream resumes -> locked returns after 4 further good words.
- din = 16'h0000 continuously after reset -> locked stays 0 indefinitely.
- ERRCNT_WIDTH = 4, inject 20 single-bit errors while locked -> err_count stops at 15; pulse clr -> 0; clr with simultaneous error -> 0.
- Clean stream with din_valid toggling 1/0 every cycle -> lock after 6 valid words, zero errors; assert reset while locked -> all outputs 0 immediately, relock after 6 valid words.
